// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Fetch-stage dynamic branch predictor. A direct-mapped branch target buffer
//   holds one entry per index. Each entry has a valid bit, a tag, a target, a
//   jump flag and a 2-bit saturating direction counter. The lookup for pcF is
//   purely combinational from registered state. Branch resolutions from
//   execute train the table at the rising clock edge.
//
//   Optional feature macro: BP_PERF_EN
//     When defined, this block adds the saturating 32-bit counters
//     perf_branches and perf_mispredicts.
//
// Parameters
//   ENTRIES          number of BTB entries (power of two, >= 4)
//
// Ports
//   clk              clock, all state updates on rising edge
//   rst              synchronous reset, active-high (wins over upd_valid)
//   pcF              fetch PC to predict
//   pred_taken       predicted redirect for pcF
//   pred_target      predicted next PC for pcF (pcF+4 when not taken)
//   upd_valid        resolved control transfer in execute this cycle
//   upd_pc           PC of the resolved instruction
//   upd_taken        resolved outcome
//   upd_is_jump      1 = JAL/JALR, 0 = conditional branch
//   upd_target       resolved target address
//   upd_pred_taken   prediction carried down the pipe
//   upd_pred_target  predicted target carried down the pipe
//   perf_branches    (BP_PERF_EN) count of resolved control transfers
//   perf_mispredicts (BP_PERF_EN) count of direction/target mispredicts
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_is_jump,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target
`ifdef BP_PERF_EN
  ,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             is_jump;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t r_btb [ENTRIES];

  // -------------------------------------------------------------------------
  // Fetch lookup (zero latency, no write-to-read bypass)
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] w_idx_f;
  logic [TAG_W-1:0] w_tag_f;
  btb_entry_t       w_ent_f;
  logic             w_hit_f;
  logic             w_taken_f;

  assign w_idx_f   = pcF[IDX_W+1:2];
  assign w_tag_f   = pcF[31:IDX_W+2];
  assign w_ent_f   = r_btb[w_idx_f];
  assign w_hit_f   = w_ent_f.valid & (w_ent_f.tag == w_tag_f);
  assign w_taken_f = w_hit_f & (w_ent_f.is_jump | w_ent_f.ctr[1]);

  assign pred_taken  = w_taken_f;
  // The +4 wraps naturally in 32 bits.
  assign pred_target = w_taken_f ? w_ent_f.target : (pcF + 32'd4);

  // -------------------------------------------------------------------------
  // Training path
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] w_idx_u;
  logic [TAG_W-1:0] w_tag_u;
  btb_entry_t       w_ent_u;
  logic             w_hit_u;
  logic [1:0]       w_ctr_inc;
  logic [1:0]       w_ctr_dec;

  assign w_idx_u = upd_pc[IDX_W+1:2];
  assign w_tag_u = upd_pc[31:IDX_W+2];
  assign w_ent_u = r_btb[w_idx_u];
  assign w_hit_u = w_ent_u.valid & (w_ent_u.tag == w_tag_u);

  // Saturating counter steps.
  assign w_ctr_inc = (w_ent_u.ctr == 2'b11) ? 2'b11 : (w_ent_u.ctr + 2'd1);
  assign w_ctr_dec = (w_ent_u.ctr == 2'b00) ? 2'b00 : (w_ent_u.ctr - 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb[i].valid   <= 1'b0;
        r_btb[i].tag     <= '0;
        r_btb[i].target  <= '0;
        r_btb[i].is_jump <= 1'b0;
        r_btb[i].ctr     <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_is_jump) begin
        // Jumps always (re)allocate, whatever currently lives in the slot.
        r_btb[w_idx_u].valid   <= 1'b1;
        r_btb[w_idx_u].tag     <= w_tag_u;
        r_btb[w_idx_u].target  <= upd_target;
        r_btb[w_idx_u].is_jump <= 1'b1;
        r_btb[w_idx_u].ctr     <= 2'b11;
      end else if (upd_taken) begin
        if (w_hit_u) begin
          r_btb[w_idx_u].ctr     <= w_ctr_inc;
          r_btb[w_idx_u].target  <= upd_target;
          r_btb[w_idx_u].is_jump <= 1'b0;
        end else begin
          // Allocate weakly-taken; evicts any alias at this index.
          r_btb[w_idx_u].valid   <= 1'b1;
          r_btb[w_idx_u].tag     <= w_tag_u;
          r_btb[w_idx_u].target  <= upd_target;
          r_btb[w_idx_u].is_jump <= 1'b0;
          r_btb[w_idx_u].ctr     <= 2'b10;
        end
      end else if (w_hit_u) begin
        // Not-taken misses never allocate.
        r_btb[w_idx_u].ctr <= w_ctr_dec;
      end
    end
  end

`ifdef BP_PERF_EN
  // -------------------------------------------------------------------------
  // Performance counters (saturating)
  // -------------------------------------------------------------------------
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispredicts;
  logic        w_mispredict;

  assign w_mispredict = (upd_pred_taken != upd_taken) |
                        (upd_taken & (upd_pred_target != upd_target));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else if (upd_valid) begin
      if (r_perf_branches != 32'hFFFF_FFFF) begin
        r_perf_branches <= r_perf_branches + 32'd1;
      end
      if (w_mispredict && (r_perf_mispredicts != 32'hFFFF_FFFF)) begin
        r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end
    end
  end

  assign perf_branches    = r_perf_branches;
  assign perf_mispredicts = r_perf_mispredicts;
`endif

  // Byte-offset bits and (without the perf counters) the carried-down
  // prediction are architecturally don't-care here.
  logic w_unused_bits;
  assign w_unused_bits = ^{pcF[1:0], upd_pc[1:0], upd_pred_taken, upd_pred_target};

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (ENTRIES = 16: index = pc[5:2],
// tag = pc[31:6]; 0x100/0x140/0x180/0x200/0x240 all share index 0).
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_is_jump;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
`ifdef BP_PERF_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  branch_predictor #(.ENTRIES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .pcF             (pcF),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_is_jump     (upd_is_jump),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target)
`ifdef BP_PERF_EN
    ,
    .perf_branches   (perf_branches),
    .perf_mispredicts(perf_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          kind;   // 0 = prediction, 1 = perf counters
    logic        et;
    logic [31:0] etgt;
    logic [31:0] ea;
    logic [31:0] eb;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: the prediction is always presented; one expectation per cycle
  // is checked mid-cycle, away from the sampling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (e.kind == 0) begin
        if (pred_taken !== e.et || pred_target !== e.etgt) begin
          miscompares++;
          $display("FAIL %s: got taken=%0b target=%08h, want taken=%0b target=%08h",
                   e.nm, pred_taken, pred_target, e.et, e.etgt);
        end
      end else begin
`ifdef BP_PERF_EN
        if (perf_branches !== e.ea || perf_mispredicts !== e.eb) begin
          miscompares++;
          $display("FAIL %s: got branches=%08h mispredicts=%08h, want %08h %08h",
                   e.nm, perf_branches, perf_mispredicts, e.ea, e.eb);
        end
`endif
      end
    end
  end

  task automatic upd(input logic [31:0] pc, input logic tk, input logic jmp,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_is_jump     = jmp;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
  endtask

  // One cycle: present pc, optionally queue an expectation, then let the edge
  // commit any pending update.
  task automatic tick(input logic [31:0] pc, input bit chk, input logic et,
                      input logic [31:0] etgt, input string nm);
    exp_t e;
    pcF = pc;
    if (chk) begin
      e.nm = nm; e.kind = 0; e.et = et; e.etgt = etgt; e.ea = '0; e.eb = '0;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    rst       = 1'b0;
  endtask

`ifdef BP_PERF_EN
  task automatic tick_perf(input logic [31:0] ea, input logic [31:0] eb, input string nm);
    exp_t e;
    e.nm = nm; e.kind = 1; e.et = 1'b0; e.etgt = '0; e.ea = ea; e.eb = eb;
    q.push_back(e);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    rst       = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; pcF = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_is_jump = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick(32'h0, 0, 0, 0, "");

    // 1: reset state
    tick(32'h0000_0100, 1, 0, 32'h0000_0104, "rst_0x100");
    tick(32'hFFFF_FFFC, 1, 0, 32'h0000_0000, "rst_wrap");
    tick(32'h0000_0240, 1, 0, 32'h0000_0244, "rst_0x240");

    // 2: taken training, no same-cycle bypass
    upd(32'h100, 1, 0, 32'h80, 0, 0);
    tick(32'h100, 1, 0, 32'h104, "train_same_cycle");
    tick(32'h100, 1, 1, 32'h80, "train_next_cycle");

    // 3: decay to 00, floor, climb back, ceiling, target overwrite
    upd(32'h100, 0, 0, 32'h0, 0, 0);
    tick(32'h100, 1, 1, 32'h80, "nt1_pre");           // 10 -> 01
    upd(32'h100, 0, 0, 32'h0, 0, 0);
    tick(32'h100, 1, 0, 32'h104, "nt2_pre");          // 01 -> 00
    upd(32'h100, 0, 0, 32'h0, 0, 0);
    tick(32'h100, 1, 0, 32'h104, "nt3_floor");        // 00 stays
    upd(32'h100, 1, 0, 32'h80, 0, 0);
    tick(32'h100, 1, 0, 32'h104, "t1_from_00");       // 00 -> 01
    upd(32'h100, 1, 0, 32'h80, 0, 0);
    tick(32'h100, 1, 0, 32'h104, "t2_from_01");       // 01 -> 10
    tick(32'h100, 1, 1, 32'h80, "retrained");
    upd(32'h100, 1, 0, 32'h80, 0, 0);
    tick(32'h100, 0, 0, 0, "");                       // 10 -> 11
    upd(32'h100, 1, 0, 32'h90, 0, 0);
    tick(32'h100, 0, 0, 0, "");                       // 11 stays, tgt 0x90
    upd(32'h100, 0, 0, 32'h0, 0, 0);
    tick(32'h100, 0, 0, 0, "");                       // 11 -> 10
    tick(32'h100, 1, 1, 32'h90, "ceiling_retarget");

    // 4: aliasing at index 0
    tick(32'h140, 1, 0, 32'h144, "alias_miss");
    upd(32'h140, 1, 0, 32'h300, 0, 0);
    tick(32'h140, 1, 0, 32'h144, "alias_alloc_same");
    tick(32'h100, 1, 0, 32'h104, "evicted_0x100");
    tick(32'h140, 1, 1, 32'h300, "alias_resident");
    upd(32'h180, 0, 0, 32'h0, 0, 0);
    tick(32'h180, 0, 0, 0, "");
    tick(32'h180, 1, 0, 32'h184, "nt_miss_no_alloc");
    tick(32'h140, 1, 1, 32'h300, "nt_miss_keeps");
    upd(32'h104, 1, 0, 32'h500, 0, 0);
    tick(32'h104, 0, 0, 0, "");
    tick(32'h104, 1, 1, 32'h500, "idx1_alloc");
    tick(32'h140, 1, 1, 32'h300, "idx0_untouched");

    // 5: jump, then reset beats a same-cycle update
    upd(32'h200, 1, 1, 32'h400, 0, 0);
    tick(32'h200, 0, 0, 0, "");
    tick(32'h200, 1, 1, 32'h400, "jal_hit");
    upd(32'h200, 0, 0, 32'h0, 0, 0);
    tick(32'h200, 0, 0, 0, "");                       // ctr 11 -> 10
    upd(32'h200, 0, 0, 32'h0, 0, 0);
    tick(32'h200, 0, 0, 0, "");                       // ctr 10 -> 01
    tick(32'h200, 1, 1, 32'h400, "jump_ignores_ctr");
    rst = 1'b1;
    upd(32'h240, 1, 0, 32'h600, 0, 0);
    tick(32'h240, 0, 0, 0, "");
    tick(32'h200, 1, 0, 32'h204, "rst_clears_jal");
    tick(32'h240, 1, 0, 32'h244, "rst_beats_upd");
    tick(32'h104, 1, 0, 32'h108, "rst_clears_idx1");

`ifdef BP_PERF_EN
    // 6: performance counters
    rst = 1'b1;
    tick(32'h0, 0, 0, 0, "");
    upd(32'h100, 1, 0, 32'h80, 0, 32'h104);           // mispredict
    tick(32'h0, 0, 0, 0, "");
    upd(32'h200, 1, 1, 32'h400, 1, 32'h400);          // correct
    tick(32'h0, 0, 0, 0, "");
    upd(32'h100, 0, 0, 32'h0, 0, 32'h104);            // correct
    tick(32'h0, 0, 0, 0, "");
    tick_perf(32'd3, 32'd1, "perf_counts");
    rst = 1'b1;
    tick(32'h0, 0, 0, 0, "");
    tick_perf(32'd0, 32'd0, "perf_reset");
    force dut.r_perf_branches = 32'hFFFF_FFFF;
    force dut.r_perf_mispredicts = 32'hFFFF_FFFF;
    #1;
    release dut.r_perf_branches;
    release dut.r_perf_mispredicts;
    upd(32'h100, 1, 0, 32'h80, 0, 32'h0);
    tick(32'h0, 0, 0, 0, "");
    tick_perf(32'hFFFF_FFFF, 32'hFFFF_FFFF, "perf_saturate");
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer with a 2-bit saturating direction counter per entry. It gives a zero-latency taken/target prediction for the fetch PC. Execute stage branch resolution (the br_taken result, resolved target and jump flag) trains it. It sits between the PC-select mux in fetch and the execute-stage branch-condition logic, closing the predict/resolve loop.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, minimum 4
IDX_W, $clog2(ENTRIES), index width; derived, not overridden
TAG_W, 30-IDX_W, tag width taken from pc[31:IDX_W+2]; derived

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
pcF  input  32  fetch PC to predict
pred_taken  output  1  predicted redirect for pcF
pred_target  output  32  predicted next PC for pcF
upd_valid  input  1  resolved control-transfer instruction in execute this cycle
upd_pc  input  32  PC of resolved instruction
upd_taken  input  1  resolved outcome (br_taken)
upd_is_jump  input  1  1 = JAL/JALR, 0 = conditional branch
upd_target  input  32  resolved target address
upd_pred_taken  input  1  prediction carried down the pipe for this instruction
upd_pred_target  input  32  predicted target carried down the pipe

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Per entry state: valid (1), tag (TAG_W), target (32), is_jump (1), ctr (2).
- Reset: all valid=0, tag=0, target=0, is_jump=0, ctr=2'b01. rst has priority over upd_valid in the same cycle.
- Lookup is combinational from registered state, 0-cycle latency:
  - hit = valid[idx] & (tag[idx]==tagF).
  - pred_taken = hit & (is_jump[idx] | ctr[idx][1]).
  - pred_target = pred_taken ? target[idx] : pcF+4. The +4 wraps modulo 2^32, so 0xFFFFFFFC gives 0x00000000.
- After reset, pred_taken=0 and pred_target=pcF+4 for all pcF.
- Update happens at the clock edge when upd_valid=1. uhit is the hit test evaluated for upd_pc.
  - Jump (upd_is_jump=1): write valid=1, tag, target=upd_target, is_jump=1, ctr=2'b11. This applies regardless of uhit.
  - Branch taken, uhit=1: ctr=min(ctr+1,3); target overwritten with upd_target; is_jump=0.
  - Branch taken, uhit=0: allocate or replace the entry with valid=1, new tag, target, is_jump=0, ctr=2'b10.
  - Branch not-taken, uhit=1: ctr=max(ctr-1,0); valid, tag and target unchanged.
  - Branch not-taken, uhit=0: no state change, no allocation.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. There is no write-to-read bypass, and the new contents are visible on the next cycle.
- One update per cycle maximum. upd_* are ignored when upd_valid=0.
- A tag alias (same index, different tag) is a miss. A taken update to the alias replaces the resident entry.

Optional Feature:
Macro BP_PERF_EN.
- Defined:
  - Adds outputs perf_branches (32) and perf_mispredicts (32), both reset to 0 by rst.
  - perf_branches increments on every upd_valid.
  - perf_mispredicts increments when upd_valid & ((upd_pred_taken!=upd_taken) | (upd_taken & upd_pred_target!=upd_target)).
  - Both counters saturate at 32'hFFFFFFFF and never wrap.
- Undefined: ports and counters are absent; the predictor is otherwise identical.

Test Plan:
1. Reset, then pcF=0x100 -> pred_taken=0, pred_target=0x104. Also pcF=0xFFFFFFFC -> pred_target=0x00000000.
2. Taken branch training, ENTRIES=16:
   - Drive upd_valid=1, upd_pc=0x100, upd_taken=1, upd_is_jump=0, upd_target=0x80.
   - Same cycle, pcF=0x100 -> pred_taken=0.
   - Next cycle, pcF=0x100 -> pred_taken=1, pred_target=0x80 (ctr=10).
3. Counter decay, continuing from 2:
   - Two not-taken updates at 0x100 -> pred_taken=0, pred_target=0x104 (ctr=00).
   - A third not-taken update -> ctr stays 00.
   - Two taken updates -> pred_taken=1 again.
4. Aliasing, continuing from 2: pcF=0x140 (index 0, different tag) -> pred_taken=0. A taken update at 0x140 with target 0x300 evicts the entry: pcF=0x100 then misses, and pcF=0x140 -> 0x300.
5. Jump and reset:
   - JAL update at pc=0x200, target 0x400 -> pcF=0x200 predicts taken, 0x400.
   - rst asserted together with a taken update at 0x240 -> next cycle, both 0x200 and 0x240 miss.
6. BP_PERF_EN defined:
   - Three updates, one with upd_pred_taken=0 and upd_taken=1 -> perf_branches=3, perf_mispredicts=1.
   - rst -> both 0.
   - Preload near saturation: at 0xFFFFFFFF, further updates hold the value.
